// File: rtl/mem_stage_sequencer_pkg.sv
// Shared definitions for the MEM-stage sequencer.
//  - state_e: FSM state encoding (2'd3 is unused and decodes back to StRun).
//  - Default parameter values for the sequencer and its wait counter.
package mem_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2
  } state_e;

  localparam int unsigned DefTimeoutW    = 8;
  localparam int unsigned DefMemTimeout  = 255;
  localparam int unsigned DefFlushCycles = 1;

endpackage

// File: rtl/seq_wait_counter.sv
// Wait/flush-length counter for the MEM-stage sequencer.
// Ports:
//  clk      rising-edge clock
//  reset    asynchronous active-low reset
//  clear_i  synchronous clear to 0 (wins over en_i)
//  en_i     count up by one, saturating at all-ones
//  term_i   terminal value to compare against
//  tc_o     current count equals term_i
module seq_wait_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] term_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/mem_stage_sequencer.sv
// MEM-stage sequencer: runs the data-memory request/ack handshake, stalls the
// front of the pipeline while an access waits, bubbles MEM/WB, and drives the
// pipeline-wide interrupt flush (with EPC capture).
// Ports:
//  clk, reset          clock, asynchronous active-low reset
//  mem_access_m        instruction in MEM is a load/store
//  mem_ready           data memory completes the access this cycle
//  interrupt_in        masked interrupt level from CP0
//  mem_req             access request, held until mem_ready
//  stall_pipe          freeze PC, IF/ID, ID/EX, EX/MEM
//  bubble_w            clear MEM/WB control this cycle
//  interrupt_request   flush all stage carriers
//  epc_we              CP0 captures EPC from the MEM-stage PC
//  bus_error           one-cycle pulse on access timeout
//  state_o             current FSM state (debug)
module mem_stage_sequencer
  import mem_stage_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_W    = DefTimeoutW,
  parameter int unsigned MEM_TIMEOUT  = DefMemTimeout,
  parameter int unsigned FLUSH_CYCLES = DefFlushCycles
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_access_m,
  input  logic       mem_ready,
  input  logic       interrupt_in,
  output logic       mem_req,
  output logic       stall_pipe,
  output logic       bubble_w,
  output logic       interrupt_request,
  output logic       epc_we,
  output logic       bus_error,
  output logic [1:0] state_o
);

  localparam logic [TIMEOUT_W-1:0] TimeoutTerm = TIMEOUT_W'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] FlushTerm   = TIMEOUT_W'(FLUSH_CYCLES - 1);

  state_e state_d, state_q;
  logic   pending_d, pending_q;

  logic                 cnt_clr, cnt_en, cnt_tc;
  logic [TIMEOUT_W-1:0] cnt_term;

  logic req, stall, bubble, ireq, epc, berr;

  seq_wait_counter #(
    .Width(TIMEOUT_W)
  ) u_wait_counter (
    .clk    (clk),
    .reset  (reset),
    .clear_i(cnt_clr),
    .en_i   (cnt_en),
    .term_i (cnt_term),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cnt_term  = TimeoutTerm;
    req       = 1'b0;
    stall     = 1'b0;
    bubble    = 1'b0;
    ireq      = 1'b0;
    epc       = 1'b0;
    berr      = 1'b0;

    case (state_q)
      StRun: begin
        // A live interrupt level counts as pending in RUN: no new access is
        // issued, and this cycle is the single RUN cycle of interrupt entry.
        if (pending_q || interrupt_in) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = StFlush;
          cnt_clr = 1'b1;
        end else if (mem_access_m) begin
          req = 1'b1;
          if (!mem_ready) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = StMemWait;
            cnt_clr = 1'b1;
          end
        end
      end

      StMemWait: begin
        req    = 1'b1;
        cnt_en = 1'b1;
        // Interrupts never abort an access in flight; remember them instead.
        if (interrupt_in) begin
          pending_d = 1'b1;
        end
        if (mem_ready) begin
          state_d = StRun;
        end else if (cnt_tc) begin
          // Faulting instruction must not reach WB, so keep it bubbled.
          berr    = 1'b1;
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = StFlush;
          cnt_clr = 1'b1;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end

      StFlush: begin
        ireq     = 1'b1;
        epc      = 1'b1;
        cnt_en   = 1'b1;
        cnt_term = FlushTerm;
        if (cnt_tc) begin
          state_d = StRun;
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase

    // Entering FLUSH services whatever was pending.
    if ((state_d == StFlush) && (state_q != StFlush)) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Outputs are forced low while reset is asserted, even if MEM holds an
  // access, so mem_req drops immediately.
  assign mem_req           = req & reset;
  assign stall_pipe        = stall & reset;
  assign bubble_w          = bubble & reset;
  assign interrupt_request = ireq & reset;
  assign epc_we            = epc & reset;
  assign bus_error         = berr & reset;
  assign state_o           = state_q;

endmodule

// File: tb/tb_mem_stage_sequencer.sv
module tb_mem_stage_sequencer;

  localparam int unsigned TW = 8;
  localparam int unsigned MT = 8;
  localparam int unsigned FC = 3;

  // Expected output packing: {req, stall, bubble, ireq, epc, berr, state[1:0]}
  localparam logic [7:0] IDLE = 8'b000000_00;
  localparam logic [7:0] ZW   = 8'b100000_00;  // RUN, zero-wait access
  localparam logic [7:0] ST0  = 8'b111000_00;  // RUN, access starts waiting
  localparam logic [7:0] ST1  = 8'b111000_01;  // MEM_WAIT, still waiting
  localparam logic [7:0] ACK1 = 8'b100000_01;  // MEM_WAIT, ack cycle
  localparam logic [7:0] PEND = 8'b011000_00;  // RUN, interrupt entry cycle
  localparam logic [7:0] FL   = 8'b000110_10;  // FLUSH
  localparam logic [7:0] BERR = 8'b111001_01;  // MEM_WAIT, timeout

  typedef struct {
    string      name;
    logic       rst_n;
    logic       acc;
    logic       rdy;
    logic       irq;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_access_m, mem_ready, interrupt_in;
  logic       mem_req, stall_pipe, bubble_w, interrupt_request, epc_we, bus_error;
  logic [1:0] state_o;

  logic [7:0] exp_q[$];
  vec_t       vecs[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  mem_stage_sequencer #(
    .TIMEOUT_W   (TW),
    .MEM_TIMEOUT (MT),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_access_m     (mem_access_m),
    .mem_ready        (mem_ready),
    .interrupt_in     (interrupt_in),
    .mem_req          (mem_req),
    .stall_pipe       (stall_pipe),
    .bubble_w         (bubble_w),
    .interrupt_request(interrupt_request),
    .epc_we           (epc_we),
    .bus_error        (bus_error),
    .state_o          (state_o)
  );

  function automatic vec_t mk(string n, logic r, logic a, logic d, logic i, logic [7:0] e);
    vec_t v;
    v.name  = n;
    v.rst_n = r;
    v.acc   = a;
    v.rdy   = d;
    v.irq   = i;
    v.exp   = e;
    return v;
  endfunction

  task automatic check(input string name);
    logic [7:0] got, want;
    got = {mem_req, stall_pipe, bubble_w, interrupt_request, epc_we, bus_error, state_o};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %b", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_err++;
        $display("FAIL %s: got %b required %b (req,stall,bub,ireq,epc,berr,st)",
                 name, got, want);
      end
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    reset        = v.rst_n;
    mem_access_m = v.acc;
    mem_ready    = v.rdy;
    interrupt_in = v.irq;
    exp_q.push_back(v.exp);
    @(negedge clk);
    check(v.name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    mem_access_m = 1'b0;
    mem_ready    = 1'b0;
    interrupt_in = 1'b0;

    //                    name          rst acc rdy irq  expected
    vecs.push_back(mk("reset_acc",     0, 1, 0, 0, IDLE));
    vecs.push_back(mk("idle",          1, 0, 0, 0, IDLE));
    // zero-wait access
    vecs.push_back(mk("zw_access",     1, 1, 1, 0, ZW));
    vecs.push_back(mk("zw_after",      1, 0, 0, 0, IDLE));
    // ready after 4 stall cycles
    vecs.push_back(mk("w4_start",      1, 1, 0, 0, ST0));
    vecs.push_back(mk("w4_wait1",      1, 1, 0, 0, ST1));
    vecs.push_back(mk("w4_wait2",      1, 1, 0, 0, ST1));
    vecs.push_back(mk("w4_wait3",      1, 1, 0, 0, ST1));
    vecs.push_back(mk("w4_ack",        1, 1, 1, 0, ACK1));
    vecs.push_back(mk("w4_run",        1, 0, 0, 0, IDLE));
    // interrupt during a 5-cycle wait is deferred
    vecs.push_back(mk("irqw_start",    1, 1, 0, 0, ST0));
    vecs.push_back(mk("irqw_irq",      1, 1, 0, 1, ST1));
    vecs.push_back(mk("irqw_wait2",    1, 1, 0, 0, ST1));
    vecs.push_back(mk("irqw_wait3",    1, 1, 0, 0, ST1));
    vecs.push_back(mk("irqw_wait4",    1, 1, 0, 0, ST1));
    vecs.push_back(mk("irqw_ack",      1, 1, 1, 0, ACK1));
    vecs.push_back(mk("irqw_entry",    1, 1, 0, 0, PEND));
    vecs.push_back(mk("irqw_flush0",   1, 1, 0, 0, FL));
    vecs.push_back(mk("irqw_flush1",   1, 1, 0, 0, FL));
    vecs.push_back(mk("irqw_flush2",   1, 1, 0, 0, FL));
    vecs.push_back(mk("irqw_run",      1, 0, 0, 0, IDLE));
    // interrupt in RUN suppresses a new access; irq in FLUSH is not latched
    vecs.push_back(mk("irqr_entry",    1, 1, 0, 1, PEND));
    vecs.push_back(mk("irqr_flush0",   1, 1, 0, 0, FL));
    vecs.push_back(mk("irqr_flush1",   1, 1, 0, 1, FL));
    vecs.push_back(mk("irqr_flush2",   1, 1, 0, 0, FL));
    vecs.push_back(mk("irqr_issue",    1, 1, 1, 0, ZW));
    vecs.push_back(mk("irqr_idle",     1, 0, 0, 0, IDLE));
    // timeout: MEM_TIMEOUT=8 waits in MEM_WAIT
    vecs.push_back(mk("to_start",      1, 1, 0, 0, ST0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk($sformatf("to_wait%0d", i), 1, 1, 0, 0, ST1));
    vecs.push_back(mk("to_buserr",     1, 1, 0, 0, BERR));
    vecs.push_back(mk("to_flush0_rdy", 1, 1, 1, 0, FL));
    vecs.push_back(mk("to_flush1",     1, 1, 0, 0, FL));
    vecs.push_back(mk("to_flush2",     1, 1, 0, 0, FL));
    vecs.push_back(mk("to_run",        1, 0, 0, 0, IDLE));
    // reset in the middle of MEM_WAIT
    vecs.push_back(mk("rst_start",     1, 1, 0, 0, ST0));
    vecs.push_back(mk("rst_wait",      1, 1, 0, 0, ST1));
    vecs.push_back(mk("rst_hold0",     0, 1, 0, 0, IDLE));
    vecs.push_back(mk("rst_hold1",     0, 1, 0, 1, IDLE));
    vecs.push_back(mk("rst_hold2",     0, 1, 1, 0, IDLE));
    vecs.push_back(mk("rst_rel_zw",    1, 1, 1, 0, ZW));
    vecs.push_back(mk("rst_rel_wait",  1, 1, 0, 0, ST0));
    vecs.push_back(mk("rst_rel_ack",   1, 1, 1, 0, ACK1));
    vecs.push_back(mk("rst_rel_idle",  1, 0, 1, 0, IDLE));

    foreach (vecs[k]) step(vecs[k]);

    // Hand-written sequences: an access that waits n cycles stalls n cycles.
    for (int n = 1; n <= 6; n++) begin
      step(mk($sformatf("nwait%0d_start", n), 1, 1, 0, 0, ST0));
      for (int w = 1; w < n; w++) begin
        step(mk($sformatf("nwait%0d_w%0d", n, w), 1, 1, 0, 0, ST1));
      end
      step(mk($sformatf("nwait%0d_ack", n), 1, 1, 1, 0, ACK1));
      step(mk($sformatf("nwait%0d_idle", n), 1, 0, 0, 0, IDLE));
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
